// File: rtl/mbus_tx_sequencer.sv
// mbus_tx_sequencer: host-side transmit front end for the MBus TX port.
// Data words are pushed into a FIFO; a message command (address, length,
// priority) then streams that many words out with the TX_REQ/TX_ACK
// four-phase handshake, chains them with TX_PEND, collects TX_SUCC/TX_FAIL,
// answers with TX_RESP_ACK and reports DONE plus STATUS to the host.
//
// Optional feature macro: MBUS_TX_RETRY_EN
//   Undefined (default): words are popped on TX_ACK, a failure ends the message.
//   Defined: words stay in the FIFO until TX_SUCC; a failed message is resent
//   from its first word up to MAX_RETRY more times before DONE reports failure.
//
// Handshake semantics:
//   Host command:  CMD_VALID is held with stable CMD_ADDR/LEN/PRIORITY until a
//                  one-cycle CMD_ACK pulse; the command is consumed at that edge.
//   Host data:     WR_EN pushes WR_DATA on any edge where FIFO_FULL is low;
//                  a push while full is dropped and latches OVERFLOW.
//   MBus word:     TX_REQ rises with TX_DATA/TX_PEND stable, falls after TX_ACK
//                  is seen; the next word waits until TX_ACK has returned low.
//   MBus response: TX_RESP_ACK rises after TX_SUCC or TX_FAIL, falls once both
//                  have returned low.
// Debug: dbg_state shows the FSM state, dbg_retry the current retry count
// (always zero when the retry feature is not built).

module mbus_tx_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 5,
  parameter int MAX_RETRY  = 3
) (
  input  logic                          CLK,
  input  logic                          RESETn,
  input  logic                          WR_EN,
  input  logic [DATA_WIDTH-1:0]         WR_DATA,
  output logic                          FIFO_FULL,
  output logic [LEN_WIDTH-1:0]          FIFO_COUNT,
  output logic                          OVERFLOW,
  input  logic                          CMD_VALID,
  input  logic [ADDR_WIDTH-1:0]         CMD_ADDR,
  input  logic [LEN_WIDTH-1:0]          CMD_LEN,
  input  logic                          CMD_PRIORITY,
  output logic                          CMD_ACK,
  output logic                          DONE,
  output logic [1:0]                    STATUS,
  output logic                          BUSY,
  output logic [ADDR_WIDTH-1:0]         TX_ADDR,
  output logic [DATA_WIDTH-1:0]         TX_DATA,
  output logic                          TX_REQ,
  output logic                          TX_PEND,
  output logic                          TX_PRIORITY,
  input  logic                          TX_ACK,
  input  logic                          TX_SUCC,
  input  logic                          TX_FAIL,
  output logic                          TX_RESP_ACK,
  output logic [3:0]                    dbg_state,
  output logic [$clog2(MAX_RETRY+1)-1:0] dbg_retry
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int RETRY_W = $clog2(MAX_RETRY+1);
  localparam logic [LEN_WIDTH-1:0] DEPTH_L = LEN_WIDTH'(FIFO_DEPTH);
  localparam logic [LEN_WIDTH-1:0] ONE_L   = LEN_WIDTH'(1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_BADLEN  = 4'd1;
  localparam logic [3:0] S_LOAD    = 4'd2;
  localparam logic [3:0] S_REQ     = 4'd3;
  localparam logic [3:0] S_ACKWAIT = 4'd4;
  localparam logic [3:0] S_RESP    = 4'd5;
  localparam logic [3:0] S_RESPACK = 4'd6;
  localparam logic [3:0] S_DISCARD = 4'd7;
`ifdef MBUS_TX_RETRY_EN
  localparam logic [3:0] S_RETRY   = 4'd8;
`endif

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LEN_WIDTH-1:0]  count;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [3:0]            state;
  logic                  push;
  logic                  adv_rd;       // read pointer steps past the head word
  logic [LEN_WIDTH-1:0]  release_cnt;  // words leaving FIFO_COUNT this cycle
  logic                  early_fail;

`ifdef MBUS_TX_RETRY_EN
  logic [PTR_W-1:0]      snap_rd_ptr;
  logic [RETRY_W-1:0]    retry_cnt;
  logic                  wait_cnt;
  logic                  final_attempt;

  // A message ends for good on success or when the retry budget is spent.
  assign final_attempt = (STATUS == 2'd0) || (retry_cnt == RETRY_W'(MAX_RETRY));
  assign dbg_retry     = retry_cnt;
`else
  assign dbg_retry     = '0;
`endif

  assign push       = WR_EN & ~FIFO_FULL;
  assign FIFO_FULL  = (count == DEPTH_L);
  assign FIFO_COUNT = count;
  assign BUSY       = (state != S_IDLE);
  assign dbg_state  = state;
  assign early_fail = TX_FAIL & ((state == S_LOAD) | (state == S_REQ) | (state == S_ACKWAIT));

  // Decide when the read side of the FIFO moves and how many words it frees.
  always_comb begin
    adv_rd      = 1'b0;
    release_cnt = '0;
`ifdef MBUS_TX_RETRY_EN
    // Sent words are only walked past; they stay counted until the outcome is final.
    if (state == S_REQ && TX_ACK && !TX_FAIL)
      adv_rd = 1'b1;
    if (state == S_RESPACK && !TX_SUCC && !TX_FAIL && final_attempt)
      release_cnt = len_q;
`else
    if ((state == S_REQ && TX_ACK && !TX_FAIL) || (state == S_DISCARD && remaining != '0)) begin
      adv_rd      = 1'b1;
      release_cnt = ONE_L;
    end
`endif
  end

  // FIFO storage: written on accepted pushes only, no reset needed.
  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= WR_DATA;
  end

  // FIFO write pointer, occupancy and the sticky overflow flag.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr   <= '0;
      count    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (WR_EN && FIFO_FULL)
        OVERFLOW <= 1'b1;
      count <= count + {{(LEN_WIDTH-1){1'b0}}, push} - release_cnt;
    end
  end

  // Message sequencer: command intake, word handshake, response handling.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state       <= S_IDLE;
      rd_ptr      <= '0;
      remaining   <= '0;
      len_q       <= '0;
      CMD_ACK     <= 1'b0;
      DONE        <= 1'b0;
      STATUS      <= 2'd0;
      TX_ADDR     <= '0;
      TX_DATA     <= '0;
      TX_REQ      <= 1'b0;
      TX_PEND     <= 1'b0;
      TX_PRIORITY <= 1'b0;
      TX_RESP_ACK <= 1'b0;
`ifdef MBUS_TX_RETRY_EN
      snap_rd_ptr <= '0;
      retry_cnt   <= '0;
      wait_cnt    <= 1'b0;
`endif
    end else begin
      CMD_ACK <= 1'b0;
      DONE    <= 1'b0;
      if (adv_rd)
        rd_ptr <= rd_ptr + 1'b1;

      if (early_fail) begin
        // The link gave up mid-message: stop requesting immediately.
        TX_REQ <= 1'b0;
`ifdef MBUS_TX_RETRY_EN
        STATUS      <= 2'd1;
        TX_RESP_ACK <= 1'b1;
        state       <= S_RESPACK;
`else
        state <= S_DISCARD;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            if (CMD_VALID) begin
              if (CMD_LEN == '0 || CMD_LEN > DEPTH_L) begin
                CMD_ACK <= 1'b1;
                state   <= S_BADLEN;
              end else if (count >= CMD_LEN) begin
                CMD_ACK     <= 1'b1;
                TX_ADDR     <= CMD_ADDR;
                TX_PRIORITY <= CMD_PRIORITY;
                remaining   <= CMD_LEN;
                len_q       <= CMD_LEN;
`ifdef MBUS_TX_RETRY_EN
                snap_rd_ptr <= rd_ptr;
                retry_cnt   <= '0;
`endif
                state       <= S_LOAD;
              end
            end
          end

          S_BADLEN: begin
            DONE   <= 1'b1;
            STATUS <= 2'd2;
            state  <= S_IDLE;
          end

          S_LOAD: begin
            TX_DATA <= mem[rd_ptr];
            TX_PEND <= (remaining > ONE_L);
            TX_REQ  <= 1'b1;
            state   <= S_REQ;
          end

          S_REQ: begin
            if (TX_ACK) begin
              TX_REQ    <= 1'b0;
              remaining <= remaining - ONE_L;
              state     <= S_ACKWAIT;
            end
          end

          S_ACKWAIT: begin
            if (!TX_ACK)
              state <= (remaining != '0) ? S_LOAD : S_RESP;
          end

          S_RESP: begin
            if (TX_SUCC) begin
              STATUS      <= 2'd0;
              TX_RESP_ACK <= 1'b1;
              state       <= S_RESPACK;
            end else if (TX_FAIL) begin
              STATUS      <= 2'd1;
              TX_RESP_ACK <= 1'b1;
              state       <= S_RESPACK;
            end
          end

          // Unsent words of an aborted message are dropped one per cycle.
          S_DISCARD: begin
            if (remaining != '0) begin
              remaining <= remaining - ONE_L;
            end else begin
              STATUS      <= 2'd1;
              TX_RESP_ACK <= 1'b1;
              state       <= S_RESPACK;
            end
          end

          S_RESPACK: begin
            if (!TX_SUCC && !TX_FAIL) begin
              TX_RESP_ACK <= 1'b0;
`ifdef MBUS_TX_RETRY_EN
              if (!final_attempt) begin
                retry_cnt <= retry_cnt + 1'b1;
                rd_ptr    <= snap_rd_ptr;
                remaining <= len_q;
                wait_cnt  <= 1'b1;
                state     <= S_RETRY;
              end else begin
                rd_ptr      <= snap_rd_ptr + len_q[PTR_W-1:0];
                DONE        <= 1'b1;
                TX_PEND     <= 1'b0;
                TX_PRIORITY <= 1'b0;
                state       <= S_IDLE;
              end
`else
              DONE        <= 1'b1;
              TX_PEND     <= 1'b0;
              TX_PRIORITY <= 1'b0;
              state       <= S_IDLE;
`endif
            end
          end

`ifdef MBUS_TX_RETRY_EN
          // Two idle cycles before the message is resent from its first word.
          S_RETRY: begin
            if (wait_cnt)
              wait_cnt <= 1'b0;
            else
              state <= S_LOAD;
          end
`endif

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
